dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single-port, synchronous-read data memory between the core load/store unit (requester 0) and a DMA/debug port (requester 1). It sits between those requesters and the data RAM and issues at most one RAM access per cycle. Write data and write enables pass through unchanged. Read data returns one cycle after a granted read, steered to the requester that issued it. Burst locking with a bounded burst length lets the DMA stream consecutive words without starving the core.

## Interface
- ADDR_W, 14: word address width (64 KB of 32-bit words)
- DATA_W, 32: data width
- MAX_BURST, 8: maximum consecutive grants to one locked requester while the other is waiting; must be ≥1
- CLK  in  1  system clock; all state changes on the rising edge
- RST  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request from requester 0 / 1
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  requester wants to keep the grant on its next request
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  access accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid (registered)
- rdata0 / rdata1  out  DATA_W  read data; equals ram_rdata while rvalid is high, 0 otherwise
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0

## Operation
- Registered state:
  - `last` (1 bit): last winner.
  - `locked_owner` (1 bit) and `lock_active` (1 bit).
  - `burst_cnt` (width clog2(MAX_BURST+1)).
  - `rd_pend` (1 bit) and `rd_id` (1 bit).
- FSM states:
  - OPEN: no lock is held.
  - LOCKED: `lock_active`=1; the locked owner is preferred.
- Winner in OPEN:
  - Only one requester asks: that requester wins.
  - Both ask: the policy defined under Configuration decides.
- Winner in LOCKED:
  - The locked owner wins if it is requesting and one of these holds: the other requester is idle, or `burst_cnt` < MAX_BURST.
  - Otherwise the other requester wins, and the next state is OPEN.
  - If the locked owner is not requesting, the other requester may win the same cycle and the state returns to OPEN.
- Granted cycle:
  - Assert `gntX` and `ram_en`.
  - Drive `ram_we`, `ram_addr`, and `ram_wdata` from the winner.
  - Set `last` to the winner.
- Lock transitions:
  - If the winner's `lockX`=1, enter or stay in LOCKED with owner = winner.
  - `burst_cnt` increments when the owner is unchanged and saturates at MAX_BURST. It reloads to 1 on a new owner.
  - If the winner's `lockX`=0, go to OPEN and clear `burst_cnt` to 0.
- Granted read:
  - Set `rd_pend`=1 and `rd_id`=winner.
  - Next cycle: `rvalidX`=1 for `rd_id` only, and `rdataX`=`ram_rdata`.
- Granted write: no response is returned.
- No requests: `ram_en`=0, and the other RAM outputs are 0. State and `burst_cnt` hold.

## Timing
- Grant latency: 0 cycles. `gnt` is combinational from `req` and the registered state.
- Read latency: exactly 1 cycle, `gnt` → `rvalid`.
- Throughput: 1 access per cycle; back-to-back reads are allowed.
- Handshake: a requester holds `req`, `we`, `addr`, and `wdata` stable until it samples `gnt`=1. There is no cancellation after grant.
- Reset (asynchronous) values:
  - All `gnt`, `rvalid`, and `ram_*` outputs = 0; all `rdata` = 0.
  - `last`=1, so requester 0 has first priority.
  - `lock_active`=0, `burst_cnt`=0, `rd_pend`=0.
- Reset asserted the cycle after a granted read: `rvalid` is suppressed and the read is lost.
- Simultaneous lock release and new lock by the other requester in one cycle: the new owner reloads `burst_cnt`=1.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN:
  - Defined: in OPEN with both requesting, the requester that is not `last` wins (alternation).
  - Undefined: requester 0 (core) always wins ties in OPEN, and `last` is unused for tie-breaking.
- LOCKED-state rules and the MAX_BURST bound apply in both builds.

## Test plan
- Reset release, `req0`=1, `we0`=0, `addr0`=0x0010 → `gnt0`=1 and `ram_en`=1 in the same cycle; next cycle `rvalid0`=1, `rdata0`=`ram_rdata`, `rvalid1`=0.
- `req0`=`req1`=1 held for 4 cycles, no lock → round-robin build grants 0,1,0,1; fixed build grants 0,0,0,0.
- `req1`+`lock1` held, `req0`=1 throughout, MAX_BURST=8 → `gnt1` for 8 consecutive cycles, then `gnt0`, and the state returns to OPEN.
- `req1`+`lock1` alone for 3 cycles, then `req0` joins (cnt=3 <8) → `gnt1` continues; drop `lock1` → `gnt0` on the next tie.
- Write `we1`=1, `addr1`=0x0003, `wdata1`=0xDEADBEEF → `ram_we`=1 with matching address and data; no `rvalid` follows.
- Granted read, RST pulsed 2 ns later → all outputs 0 immediately, no `rvalid` the next cycle, and requester 0 wins the first tie after reset.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port synchronous-read data RAM (core = 0, DMA/debug = 1).
// Build option DMEM_ARB_ROUND_ROBIN_EN: alternate open-state ties; otherwise the core wins ties.
module dmem_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic              lock0_i,
    input  logic              lock1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rd_pend_q, rd_pend_d;
    logic               rd_id_q, rd_id_d;

    logic               win_valid_s;
    logic               winner_s;
    logic               req_own_s;
    logic               req_oth_s;
    logic               win_we_s;
    logic               win_lock_s;

    assign req_own_s  = owner_q ? req1_i : req0_i;
    assign req_oth_s  = owner_q ? req0_i : req1_i;
    assign win_we_s   = winner_s ? we1_i : we0_i;
    assign win_lock_s = winner_s ? lock1_i : lock0_i;

    // Winner selection; no grant is issued while reset is held
    always_comb begin
        win_valid_s = 1'b0;
        winner_s    = 1'b0;
        if (rst_i) begin
            win_valid_s = 1'b0;
        end else if ((state_q == ST_LOCKED) && req_own_s && (!req_oth_s || (cnt_q < MAX_CNT))) begin
            win_valid_s = 1'b1;
            winner_s    = owner_q;
        end else if (req0_i && req1_i) begin
            win_valid_s = 1'b1;
            if (state_q == ST_LOCKED) begin
                winner_s = ~owner_q;
            end else begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                winner_s = ~last_q;
`else
                winner_s = 1'b0;
`endif
            end
        end else if (req0_i) begin
            win_valid_s = 1'b1;
            winner_s    = 1'b0;
        end else if (req1_i) begin
            win_valid_s = 1'b1;
            winner_s    = 1'b1;
        end else begin
            win_valid_s = 1'b0;
        end
    end

    // Next-state: lock ownership, burst count and pending read tracking
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        rd_pend_d = 1'b0;
        rd_id_d   = rd_id_q;
        if (win_valid_s) begin
            last_d    = winner_s;
            rd_pend_d = ~win_we_s;
            rd_id_d   = winner_s;
            if (win_lock_s) begin
                state_d = ST_LOCKED;
                owner_d = winner_s;
                if ((state_q == ST_LOCKED) && (owner_q == winner_s)) begin
                    if (cnt_q < MAX_CNT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    cnt_d = CNT_W'(1);
                end
            end else begin
                state_d = ST_OPEN;
                cnt_d   = {CNT_W{1'b0}};
            end
        end else begin
            rd_pend_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_OPEN;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= {CNT_W{1'b0}};
            rd_pend_q <= 1'b0;
            rd_id_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    // RAM port and grant outputs; RAM fields are zero when idle
    always_comb begin
        gnt0_o      = win_valid_s & ~winner_s;
        gnt1_o      = win_valid_s & winner_s;
        ram_en_o    = win_valid_s;
        ram_we_o    = 1'b0;
        ram_addr_o  = {ADDR_W{1'b0}};
        ram_wdata_o = {DATA_W{1'b0}};
        if (win_valid_s) begin
            ram_we_o    = win_we_s;
            ram_addr_o  = winner_s ? addr1_i : addr0_i;
            ram_wdata_o = winner_s ? wdata1_i : wdata0_i;
        end else begin
            ram_we_o = 1'b0;
        end
    end

    assign rvalid0_o = rd_pend_q & ~rd_id_q;
    assign rvalid1_o = rd_pend_q & rd_id_q;
    assign rdata0_o  = rvalid0_o ? ram_rdata_i : {DATA_W{1'b0}};
    assign rdata1_o  = rvalid1_o ? ram_rdata_i : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus handshake-respecting random traffic vs a reference model.
module tb_dmem_arbiter;
    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, req1, we0, we1, lock0, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1, ram_rdata;
    logic              gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_we;
    logic [DATA_W-1:0] rdata0, rdata1, ram_wdata;
    logic [ADDR_W-1:0] ram_addr;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_locked;
    int m_owner;
    int m_cnt;
    int m_last;
    bit m_pend;
    int m_pid;

    // random traffic: per-requester pending transaction
    bit                pr[2], pw[2], pl[2];
    logic [ADDR_W-1:0] pa[2];
    logic [DATA_W-1:0] pd[2];
    int                w;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .lock0_i(lock0), .lock1_i(lock1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
        .rdata0_o(rdata0), .rdata1_o(rdata1),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_cnt    = 0;
        m_last   = 1;
        m_pend   = 1'b0;
        m_pid    = 0;
    endtask

    // who gets the RAM this cycle, -1 for nobody
    function automatic int pick(bit r0, bit r1);
        if (!r0 && !r1) return -1;
        if (r0 != r1) return r0 ? 0 : 1;
        if (m_locked) return (m_cnt < MAX_BURST) ? m_owner : 1 - m_owner;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        return 1 - m_last;
`else
        return 0;
`endif
    endfunction

    task automatic cycle(input bit r0, input bit w0, input bit l0,
                         input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input bit r1, input bit w1, input bit l1,
                         input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                         output int win);
        bit                wa[2], la[2];
        logic [ADDR_W-1:0] aa[2];
        logic [DATA_W-1:0] da[2];
        wa[0] = w0; wa[1] = w1; la[0] = l0; la[1] = l1;
        aa[0] = a0; aa[1] = a1; da[0] = d0; da[1] = d1;
        @(negedge clk);
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
        ram_rdata = $urandom;
        #1;
        win = pick(r0, r1);
        chk("gnt0", gnt0, win == 0);
        chk("gnt1", gnt1, win == 1);
        chk("ram_en", ram_en, win >= 0);
        chk("ram_we", ram_we, (win >= 0) ? wa[win] : 1'b0);
        chk("ram_addr", ram_addr, (win >= 0) ? aa[win] : '0);
        chk("ram_wdata", ram_wdata, (win >= 0) ? da[win] : '0);
        chk("rvalid0", rvalid0, m_pend && m_pid == 0);
        chk("rvalid1", rvalid1, m_pend && m_pid == 1);
        chk("rdata0", rdata0, (m_pend && m_pid == 0) ? ram_rdata : '0);
        chk("rdata1", rdata1, (m_pend && m_pid == 1) ? ram_rdata : '0);
        // model the coming rising edge
        if (win >= 0) begin
            if (la[win]) begin
                if (m_locked && m_owner == win) m_cnt = (m_cnt < MAX_BURST) ? m_cnt + 1 : MAX_BURST;
                else m_cnt = 1;
                m_locked = 1'b1;
                m_owner  = win;
            end else begin
                m_locked = 1'b0;
                m_cnt    = 0;
            end
            m_last = win;
            m_pend = !wa[win];
            m_pid  = win;
        end else begin
            m_pend = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; ram_rdata = 32'h1234_5678;
        w = -1;
        model_reset();
        #1;
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rdata1", rdata1, '0);
        @(negedge clk);
        rst = 1'b0;

        // first read by the core, then its response
        cycle(1'b1, 1'b0, 1'b0, 14'h0010, '0, 1'b0, 1'b0, 1'b0, '0, '0, w);
        chk("first_read_gnt", w, 0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, w);

        // four unlocked ties
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, 1'b0, 14'(i), '0, 1'b1, 1'b0, 1'b0, 14'(100 + i), '0, w);

        // DMA burst: alone for 3, then core waits until the burst bound
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 14'(200 + i), '0, w);
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 1'b0, 1'b0, 14'h0040, '0, 1'b1, 1'b0, 1'b1, 14'(210 + i), '0, w);
        chk("burst_bound_gnt", w, 0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, w);

        // lock released mid-burst, core wins the following tie
        for (int i = 0; i < 2; i++)
            cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 14'(300 + i), '0, w);
        cycle(1'b1, 1'b0, 1'b0, 14'h0050, '0, 1'b1, 1'b0, 1'b0, 14'h0130, '0, w);
        chk("release_last_dma", w, 1);
        cycle(1'b1, 1'b0, 1'b0, 14'h0050, '0, 1'b1, 1'b0, 1'b0, 14'h0131, '0, w);
        chk("release_tie", w, 0);

        // DMA write, no response afterwards
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 14'h0003, 32'hDEAD_BEEF, w);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, w);

        // random traffic honouring the hold-until-granted handshake
        pr[0] = 1'b0; pr[1] = 1'b0;
        w = -1;
        for (int k = 0; k < 400; k++) begin
            for (int j = 0; j < 2; j++) begin
                if (!pr[j] || w == j) begin
                    pr[j] = ($urandom_range(0, 9) < 7);
                    pw[j] = 1'($urandom_range(0, 1));
                    pl[j] = (j == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                    pa[j] = ADDR_W'($urandom);
                    pd[j] = $urandom;
                end
            end
            cycle(pr[0], pw[0], pl[0], pa[0], pd[0], pr[1], pw[1], pl[1], pa[1], pd[1], w);
        end

        // granted read, reset pulsed 2 ns after the capturing edge
        cycle(1'b1, 1'b0, 1'b0, 14'h0020, '0, 1'b0, 1'b0, 1'b0, '0, '0, w);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_gnt0", gnt0, 1'b0);
        chk("arst_ram_en", ram_en, 1'b0);
        chk("arst_ram_addr", ram_addr, '0);
        chk("arst_rvalid0", rvalid0, 1'b0);
        chk("arst_rdata0", rdata0, '0);
        model_reset();
        @(negedge clk);
        req0 = 1'b0;
        rst = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 14'h0001, '0, 1'b1, 1'b0, 1'b0, 14'h0002, '0, w);
        chk("post_rst_tie", w, 0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, w);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
